// File: rtl/axis_packetizer_flush.sv
// axis_packetizer_flush: skid-buffered AXI-Stream packetizer with beat-count tlast and idle-timeout flush.
// Define AXIS_PACKETIZER_STATS_EN to add saturating pkt_count/flush_count outputs.
module axis_packetizer_flush #(
    parameter int DATA_WIDTH        = 32,
    parameter int TDATA_WIDTH_BYTES = 8,
    parameter int PKT_SIZE          = 8,
    parameter int TIMEOUT_CYCLES    = 10,
    parameter int PAD_MODE          = 0
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic [$clog2(PKT_SIZE+1)-1:0]     cfg_pkt_size,
    input  logic                              s_tvalid,
    output logic                              s_tready,
    input  logic [DATA_WIDTH-1:0]             s_tdata,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic [8*TDATA_WIDTH_BYTES-1:0]    m_tdata,
    output logic                              m_tlast,
    output logic [TDATA_WIDTH_BYTES-1:0]      m_tkeep
`ifdef AXIS_PACKETIZER_STATS_EN
    ,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       flush_count
`endif
);
    localparam int TW   = 8*TDATA_WIDTH_BYTES;
    localparam int CW   = $clog2(PKT_SIZE+1);
    localparam int IW   = $clog2(TIMEOUT_CYCLES+1);
    localparam int PADW = TW-DATA_WIDTH-1;

    if (TW < DATA_WIDTH+1) begin : g_width_check
        $error("m_tdata too narrow for flag plus payload");
    end
    if (PKT_SIZE < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("PKT_SIZE and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

    state_t                state;
    logic                  run, skid_v;
    logic [DATA_WIDTH-1:0] skid_d, src_d;
    logic [CW-1:0]         beat_cnt, size_q, size_eff, cfg_eff;
    logic [IW-1:0]         idle_cnt;
    logic                  acc, out_free, load_real, load_fill, last, idle, tmo;

    function automatic logic [TW-1:0] fmt(input logic [DATA_WIDTH-1:0] d);
        return TW'({1'b1, d}) << PADW;
    endfunction

    assign m_tkeep   = '1;
    assign s_tready  = run && !skid_v && state != FLUSH;
    assign acc       = s_tvalid && s_tready;
    assign out_free  = !m_tvalid || m_tready;
    assign src_d     = skid_v ? skid_d : s_tdata;
    assign load_real = out_free && (skid_v || acc);
    assign load_fill = out_free && state == FLUSH && !(m_tvalid && m_tlast);
    assign cfg_eff   = (cfg_pkt_size == '0 || cfg_pkt_size > CW'(PKT_SIZE)) ? CW'(PKT_SIZE) : cfg_pkt_size;
    assign size_eff  = beat_cnt == '0 ? cfg_eff : size_q;
    // beat_cnt advances when a beat enters the output register, so tlast is registered with its beat
    assign last      = (PAD_MODE == 0 && load_fill) || beat_cnt == size_eff - CW'(1);
    assign idle      = !m_tvalid && !skid_v && !s_tvalid;
    // leave FILL one cycle early so input is already stalled when the filler is loaded
    assign tmo       = state == FILL && idle && idle_cnt == IW'(TIMEOUT_CYCLES-1);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state    <= IDLE;
            run      <= 1'b0;
            skid_v   <= 1'b0;
            skid_d   <= '0;
            beat_cnt <= '0;
            size_q   <= '0;
            idle_cnt <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else begin
            run <= 1'b1;
            if (out_free) begin
                m_tvalid <= load_real || load_fill;
                m_tdata  <= load_real ? fmt(src_d) : '0;
                m_tlast  <= (load_real || load_fill) && last;
            end
            if (load_real || load_fill) begin
                beat_cnt <= last ? '0 : beat_cnt + CW'(1);
                if (beat_cnt == '0) size_q <= cfg_eff;
            end
            if (acc && !out_free) begin
                skid_v <= 1'b1;
                skid_d <= s_tdata;
            end else if (out_free) begin
                skid_v <= 1'b0;
            end
            if (tmo) state <= FLUSH;
            else if (state == FLUSH && m_tvalid && m_tready && m_tlast) state <= IDLE;
            else if (load_real) state <= last ? IDLE : FILL;
            idle_cnt <= (state == FILL && idle && !tmo) ? idle_cnt + IW'(1) : '0;
        end
    end

`ifdef AXIS_PACKETIZER_STATS_EN
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            pkt_count   <= '0;
            flush_count <= '0;
        end else begin
            if (m_tvalid && m_tready && m_tlast && pkt_count != '1) pkt_count <= pkt_count + 32'd1;
            if (tmo && flush_count != '1) flush_count <= flush_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axis_packetizer_flush.sv
// tb_axis_packetizer_flush: directed checks of the packetizer with PAD_MODE 0 (u0) and 1 (u1) sharing stimulus.
module tb_axis_packetizer_flush;
    localparam int T = 10;

    typedef struct {
        logic [63:0] d;
        logic        l;
        int          c;
    } beat_t;

    logic        clk = 1'b0, arstn = 1'b0, s_tvalid = 1'b0, m_tready = 1'b1;
    logic [3:0]  cfg = 4'd4;
    logic [31:0] s_tdata = '0;
    logic        s0_tready, m0_tvalid, m0_tlast, s1_tready, m1_tvalid, m1_tlast;
    logic [63:0] m0_tdata, m1_tdata;
    logic [7:0]  m0_tkeep, m1_tkeep;
`ifdef AXIS_PACKETIZER_STATS_EN
    logic [31:0] pkt0, flush0, pkt1, flush1;
`endif
    int          total = 0, bad = 0, cyc = 0, stab_errs = 0, rdy_errs = 0;
    bit          rand_rdy = 0, mon4 = 0;
    logic        pv = 0, pr = 0, pl = 0;
    logic [63:0] pd = '0;
    beat_t       q0[$], q1[$];

    axis_packetizer_flush #(.DATA_WIDTH(32), .TDATA_WIDTH_BYTES(8), .PKT_SIZE(8), .TIMEOUT_CYCLES(T), .PAD_MODE(0)) u0 (
        .clk(clk), .arstn(arstn), .cfg_pkt_size(cfg), .s_tvalid(s_tvalid), .s_tready(s0_tready), .s_tdata(s_tdata),
        .m_tvalid(m0_tvalid), .m_tready(m_tready), .m_tdata(m0_tdata), .m_tlast(m0_tlast), .m_tkeep(m0_tkeep)
`ifdef AXIS_PACKETIZER_STATS_EN
        , .pkt_count(pkt0), .flush_count(flush0)
`endif
    );

    axis_packetizer_flush #(.DATA_WIDTH(32), .TDATA_WIDTH_BYTES(8), .PKT_SIZE(8), .TIMEOUT_CYCLES(T), .PAD_MODE(1)) u1 (
        .clk(clk), .arstn(arstn), .cfg_pkt_size(cfg), .s_tvalid(s_tvalid), .s_tready(s1_tready), .s_tdata(s_tdata),
        .m_tvalid(m1_tvalid), .m_tready(m_tready), .m_tdata(m1_tdata), .m_tlast(m1_tlast), .m_tkeep(m1_tkeep)
`ifdef AXIS_PACKETIZER_STATS_EN
        , .pkt_count(pkt1), .flush_count(flush1)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // handshakes are recorded at the negedge before the committing posedge
    always @(negedge clk) begin
        if (arstn && m0_tvalid && m_tready) q0.push_back('{m0_tdata, m0_tlast, cyc});
        if (arstn && m1_tvalid && m_tready) q1.push_back('{m1_tdata, m1_tlast, cyc});
        if (mon4) begin
            if (pv && !pr && !(m0_tvalid && m0_tdata == pd && m0_tlast == pl)) stab_errs++;
            if (!s0_tready && !m0_tvalid) rdy_errs++;
        end
        pv = m0_tvalid;
        pr = m_tready;
        pd = m0_tdata;
        pl = m0_tlast;
    end

    function automatic logic [63:0] word(input logic [31:0] d);
        return {1'b1, d, 31'b0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, output int ac);
        int  n;
        logic ok;
        n = 0;
        ok = 1'b0;
        s_tvalid = 1'b1;
        s_tdata = d;
        do begin
            @(negedge clk);
            ok = s0_tready;
            ac = cyc;
            n++;
            @(posedge clk);
            #1;
            if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
        end while (!ok && n < 200);
        if (!ok) chk("send_timeout", 64'(ok), 64'd1);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a, h, na, ne, nf, nl;
        logic [31:0] rv;
        logic [31:0] exp_q[$];
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 64'(m0_tvalid), 0);
        chk("rst_tlast", 64'(m0_tlast), 0);
        chk("rst_tdata", m0_tdata, 0);
        chk("rst_tready", 64'(s0_tready), 0);
        arstn = 1'b1;
        #1 chk("rel_tready_pre", 64'(s0_tready), 0);
        @(posedge clk);
        #1 chk("rel_tready", 64'(s0_tready), 1);
        chk("tkeep", 64'(m0_tkeep), 64'hff);

        cfg = 4'd4;
        q0.delete();
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), a);
            if (i == 1) na = a;
        end
        idle(5);
        chk("t1_count", 64'(q0.size()), 8);
        chk("t1_first", q0[0].d, 64'h8000_0000_8000_0000);
        chk("t1_latency", 64'(q0[0].c - na), 1);
        for (int i = 0; i < 8 && i < q0.size(); i++) begin
            chk("t1_data", q0[i].d, word(32'(i + 1)));
            chk("t1_last", 64'(q0[i].l), 64'((i % 4) == 3));
        end

        cfg = 4'd5;
        q0.delete();
        rand_rdy = 1;
        mon4 = 1;
        for (int i = 0; i < 1000; i++) begin
            rv = $urandom;
            exp_q.push_back(rv);
            send(rv, a);
        end
        rand_rdy = 0;
        m_tready = 1'b1;
        idle(10);
        mon4 = 0;
        ne = 0;
        for (int i = 0; i < q0.size() && i < 1000; i++)
            if (q0[i].d !== word(exp_q[i]) || q0[i].l !== ((i % 5) == 4)) ne++;
        chk("t4_count", 64'(q0.size()), 1000);
        chk("t4_order_last", 64'(ne), 0);
        chk("t4_stable", 64'(stab_errs), 0);
        chk("t4_ready", 64'(rdy_errs), 0);

        cfg = 4'd8;
        q0.delete();
        q1.delete();
        send(32'h11, a);
        send(32'h12, a);
        send(32'h13, a);
        idle(30);
        chk("t2_count", 64'(q0.size()), 4);
        chk("t2_real_data", q0[2].d, word(32'h13));
        chk("t2_real_last", 64'(q0[2].l), 0);
        chk("t2_fill_data", q0[3].d, 0);
        chk("t2_fill_last", 64'(q0[3].l), 1);
        chk("t2_fill_delay", 64'(q0[3].c - q0[2].c - 1), T + 1);
        nf = 0;
        nl = 0;
        for (int i = 0; i < q1.size(); i++) begin
            if (q1[i].d == 0) nf++;
            if (q1[i].l) nl++;
        end
        chk("t3_count", 64'(q1.size()), 8);
        chk("t3_fillers", 64'(nf), 5);
        chk("t3_last_cnt", 64'(nl), 1);
        chk("t3_last_pos", 64'(q1[7].l), 1);
        chk("t3_fill_delay", 64'(q1[3].c - q1[2].c - 1), T + 1);

        cfg = 4'd2;
        q0.delete();
        q1.delete();
        send(32'h21, a);
        send(32'h22, a);
        idle(3);
        chk("t3_new_first", 64'(q1[0].l), 0);
        chk("t3_new_last", 64'(q1[1].l), 1);
        chk("t3_new_last_p0", 64'(q0[1].l), 1);

        cfg = 4'd1;
        q0.delete();
        for (int i = 0; i < 3; i++) send(32'h30 + 32'(i), a);
        idle(3);
        nl = 0;
        foreach (q0[i]) if (q0[i].l) nl++;
        chk("size1_count", 64'(q0.size()), 3);
        chk("size1_lasts", 64'(nl), 3);

        cfg = 4'd8;
        q0.delete();
        send(32'h41, a);
        idle(1);
        m_tready = 1'b0;
        for (int n = 0; n < 40 && !m0_tvalid; n++) @(negedge clk);
        chk("stall_fill_seen", 64'(m0_tvalid), 1);
        #1;
        s_tvalid = 1'b1;
        s_tdata = 32'h42;
        repeat (4) begin
            @(negedge clk);
            chk("stall_tvalid", 64'(m0_tvalid), 1);
            chk("stall_tdata", m0_tdata, 0);
            chk("stall_tlast", 64'(m0_tlast), 1);
            chk("stall_tready", 64'(s0_tready), 0);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        idle(20);
        chk("stall_count", 64'(q0.size()), 2);

        q0.delete();
        send(32'h51, a);
        idle(1);
        h = q0.size() > 0 ? q0[0].c : 0;
        while (cyc < h + T) begin
            @(posedge clk);
            #1;
        end
        send(32'h52, a);
        idle(30);
        chk("t5_count", 64'(q0.size()), 3);
        chk("t5_data", q0[1].d, word(32'h52));
        chk("t5_gap", 64'(q0[1].c - h), T + 1);
        chk("t5_fill", q0[2].d, 0);
        chk("t5_fill_delay", 64'(q0[2].c - q0[1].c - 1), T + 1);

        cfg = 4'd8;
        send(32'h61, a);
        send(32'h62, a);
        s_tvalid = 1'b0;
        @(negedge clk);
        arstn = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(m0_tvalid), 0);
        chk("t6_rst_tdata", m0_tdata, 0);
        chk("t6_rst_tlast", 64'(m0_tlast), 0);
        chk("t6_rst_tready", 64'(s0_tready), 0);
`ifdef AXIS_PACKETIZER_STATS_EN
        chk("t6_rst_pkt", 64'(pkt0), 0);
        chk("t6_rst_flush", 64'(flush0), 0);
`endif
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
        cfg = 4'd4;
        for (int i = 1; i <= 4; i++) send(32'h70 + 32'(i), a);
        idle(5);
        chk("t6_count", 64'(q0.size()), 4);
        chk("t6_data", q0[0].d, word(32'h71));
        chk("t6_last3", 64'(q0[2].l), 0);
        chk("t6_last4", 64'(q0[3].l), 1);
`ifdef AXIS_PACKETIZER_STATS_EN
        chk("t6_pkt", 64'(pkt0), 1);
        chk("t6_flush", 64'(flush0), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
